// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register bank: NUM_REGS read/write 32-bit registers plus a
// read-only count of successful writes at word index NUM_REGS. Register
// contents are also exposed as a flat vector for local logic.
module axi_lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 4
) (
    input  logic                       s0_axi_aclk,
    input  logic                       s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]      s0_axi_awaddr,
    input  logic                       s0_axi_awvalid,
    output logic                       s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]      s0_axi_wdata,
    input  logic [DATA_WIDTH/8:0]      s0_axi_wstrb,
    input  logic                       s0_axi_wvalid,
    output logic                       s0_axi_wready,
    output logic                       s0_axi_bresp,
    output logic                       s0_axi_bvalid,
    input  logic                       s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]      s0_axi_araddr,
    input  logic                       s0_axi_arvalid,
    output logic                       s0_axi_arready,
    output logic [DATA_WIDTH-1:0]      s0_axi_rdata,
    output logic                       s0_axi_rresp,
    output logic                       s0_axi_rvalid,
    input  logic                       s0_axi_rready,
    output logic [NUM_REGS*32-1:0]     regs_out
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int NUM_LANES = DATA_WIDTH / 8;
    // Word index of the read-only write counter; anything above it is unmapped.
    localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [31:0]           wr_count;

    logic                  aw_held;
    logic                  w_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NUM_LANES-1:0]  w_strb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic                  wr_ok;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;

    // Byte-offset bits and the spare strobe bit carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s0_axi_wstrb[NUM_LANES], s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

    // A held address or data beat, or an unacknowledged response, blocks new writes.
    assign s0_axi_awready = !aw_held && !s0_axi_bvalid;
    assign s0_axi_wready  = !w_held && !s0_axi_bvalid;
    assign s0_axi_arready = !s0_axi_rvalid;

    assign aw_hs  = s0_axi_awvalid && s0_axi_awready;
    assign w_hs   = s0_axi_wvalid && s0_axi_wready;
    assign ar_hs  = s0_axi_arvalid && s0_axi_arready;
    assign commit = aw_held && w_held;
    assign wr_ok  = aw_idx_q < CNT_IDX;
    assign ar_idx = s0_axi_araddr[ADDR_WIDTH-1:2];

    // Collect AW and W independently, then commit one edge after both are held.
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s0_axi_bvalid <= 1'b0;
            s0_axi_bresp  <= 1'b0;
        end else if (commit) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values, which is what makes a same-edge read see the old register contents.
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s0_axi_bvalid <= 1'b1;
            s0_axi_bresp  <= !wr_ok;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s0_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s0_axi_wdata;
                w_strb_q <= s0_axi_wstrb[NUM_LANES-1:0];
            end
            if (s0_axi_bvalid && s0_axi_bready) begin
                s0_axi_bvalid <= 1'b0;
            end
        end
    end

    // Apply byte-strobed data to the addressed register and count good writes.
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            // NOTE: the register bank is a handful of flops with a defined reset value, not a RAM, so it is cleared with everything else.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (commit && wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (aw_idx_q == IDX_W'(i)) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (w_strb_q[k]) begin
                            regs[i][8*k +: 8] <= w_data_q[8*k +: 8];
                        end
                    end
                end
            end
            wr_count <= wr_count + 32'd1;
        end
    end

    // Decode the read address into data and an error flag.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        rd_data = '0;
        rd_err  = 1'b0;
        if (ar_idx < CNT_IDX) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_idx == IDX_W'(i)) begin
                    rd_data = regs[i];
                end
            end
        end else if (ar_idx == CNT_IDX) begin
            rd_data = wr_count;
        end else begin
            rd_err = 1'b1;
        end
    end

    // Register the read response on the AR handshake and hold it until taken.
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            s0_axi_rvalid <= 1'b0;
            s0_axi_rdata  <= '0;
            s0_axi_rresp  <= 1'b0;
        end else if (ar_hs) begin
            s0_axi_rvalid <= 1'b1;
            s0_axi_rdata  <= rd_data;
            s0_axi_rresp  <= rd_err;
        end else if (s0_axi_rvalid && s0_axi_rready) begin
            s0_axi_rvalid <= 1'b0;
        end
    end

    // Flatten the register bank for local logic.
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[32*i +: 32] = regs[i];
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: stimulus pushes expected write and
// read responses into queues; a monitor pops and compares them on handshake.
module tb_axi_lite_regfile;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [7:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [4:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic         bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic         rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] regs_out;

    typedef struct packed {
        logic [31:0] data;
        logic        resp;
    } rd_exp_t;

    logic    exp_b [$];
    rd_exp_t exp_r [$];

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [4];
    logic [31:0] m_count;

    always #5 aclk = ~aclk;

    axi_lite_regfile #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .NUM_REGS  (4)
    ) dut (
        .s0_axi_aclk   (aclk),
        .s0_axi_aresetn(aresetn),
        .s0_axi_awaddr (awaddr),
        .s0_axi_awvalid(awvalid),
        .s0_axi_awready(awready),
        .s0_axi_wdata  (wdata),
        .s0_axi_wstrb  (wstrb),
        .s0_axi_wvalid (wvalid),
        .s0_axi_wready (wready),
        .s0_axi_bresp  (bresp),
        .s0_axi_bvalid (bvalid),
        .s0_axi_bready (bready),
        .s0_axi_araddr (araddr),
        .s0_axi_arvalid(arvalid),
        .s0_axi_arready(arready),
        .s0_axi_rdata  (rdata),
        .s0_axi_rresp  (rresp),
        .s0_axi_rvalid (rvalid),
        .s0_axi_rready (rready),
        .regs_out      (regs_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
        m_count = 32'h0;
    endtask

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb);
        int idx;
        idx = int'(addr[7:2]);
        if (idx < 4) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) m_regs[idx][8*k +: 8] = data[8*k +: 8];
            end
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_regs_out[%0d]", tag, i), regs_out[32*i +: 32], m_regs[i]);
        end
    endtask

    // Write with W issued w_lead cycles ahead of AW (0 = same cycle).
    // Returns with bvalid visible; if bready is high the response is also taken.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                            input logic exp_resp, input int w_lead);
        int n;
        int lat;
        n   = 0;
        lat = 0;
        exp_b.push_back(exp_resp);
        wdata   = data;
        wstrb   = strb;
        awaddr  = addr;
        wvalid  = 1'b1;
        awvalid = (w_lead == 0);
        while (!wready && n < 50) begin
            tick();
            n++;
        end
        check("w_accept", wready, 1);
        if (w_lead == 0) check("aw_accept", awready, 1);
        tick();
        wvalid  = 1'b0;
        awvalid = 1'b0;
        for (int i = 0; i < w_lead; i++) begin
            check("w_only_wready", wready, 0);
            check("w_only_awready", awready, 1);
            check("w_only_bvalid", bvalid, 0);
            if (i < w_lead - 1) tick();
        end
        if (w_lead > 0) begin
            awvalid = 1'b1;
            tick();
            awvalid = 1'b0;
        end
        while (!bvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("b_latency", lat, 1);
        model_write(addr, data, strb);
        if (bready) tick();
    endtask

    // Read; returns with rvalid visible, and takes the response if rready is high.
    task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_data, input logic exp_resp);
        int n;
        rd_exp_t e;
        n = 0;
        e.data = exp_data;
        e.resp = exp_resp;
        exp_r.push_back(e);
        araddr  = addr;
        arvalid = 1'b1;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        check("ar_accept", arready, 1);
        tick();
        arvalid = 1'b0;
        check("r_latency", rvalid, 1);
        if (rready) tick();
    endtask

    // Scoreboard monitor: compare a response on the cycle it is accepted.
    initial begin
        rd_exp_t e;
        logic    eb;
        forever begin
            @(negedge aclk);
            if (aresetn === 1'b1) begin
                if (bvalid && bready) begin
                    if (exp_b.size() == 0) begin
                        check("b_unexpected", bvalid, 0);
                    end else begin
                        eb = exp_b.pop_front();
                        check("bresp", bresp, eb);
                    end
                end
                if (rvalid && rready) begin
                    if (exp_r.size() == 0) begin
                        check("r_unexpected", rvalid, 0);
                    end else begin
                        e = exp_r.pop_front();
                        check("rdata", rdata, e.data);
                        check("rresp", rresp, e.resp);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  t1_addr [5];
        logic [31:0] d;
        int          n;
        t1_addr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};

        aresetn = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tick();

        // 1: reset state and reads of every mapped word
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_arready", arready, 1);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check_regs("rst");
        for (int i = 0; i < 5; i++) do_read(t1_addr[i], 32'h0, 1'b0);

        // 2: AW and W together
        do_write(8'h04, 32'h0000001E, 5'h0F, 1'b0, 0);
        do_read(8'h04, 32'h0000001E, 1'b0);
        do_read(8'h10, 32'd1, 1'b0);

        // 3: W three cycles ahead of AW, partial strobes
        do_write(8'h08, 32'hAABBCCDD, 5'h05, 1'b0, 3);
        do_read(8'h08, 32'h00BB00DD, 1'b0);

        // 4: writes to WR_COUNT and unmapped space, unmapped read
        do_write(8'h10, 32'hDEADBEEF, 5'h0F, 1'b1, 0);
        do_write(8'h20, 32'h12345678, 5'h0F, 1'b1, 0);
        do_read(8'h20, 32'h0, 1'b1);
        check_regs("t4");
        do_read(8'h10, 32'd2, 1'b0);

        // 5: write response back-pressure (spare strobe bit set, must be ignored)
        bready = 1'b0;
        do_write(8'h0C, 32'h12345678, 5'h1F, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            check("bhold_bvalid", bvalid, 1);
            check("bhold_bresp", bresp, 0);
            check("bhold_awready", awready, 0);
            check("bhold_wready", wready, 0);
            tick();
        end
        bready = 1'b1;
        tick();
        // read back-pressure
        rready = 1'b0;
        do_read(8'h0C, 32'h12345678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("rhold_rvalid", rvalid, 1);
            check("rhold_rdata", rdata, 32'h12345678);
            check("rhold_arready", arready, 0);
            tick();
        end
        rready = 1'b1;
        tick();

        // Read of WR_COUNT on the commit edge sees the pre-increment count
        exp_b.push_back(1'b0);
        awaddr  = 8'h08;
        wdata   = 32'hCAFEF00D;
        wstrb   = 5'h03;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        begin
            rd_exp_t e;
            e.data = 32'd3;
            e.resp = 1'b0;
            exp_r.push_back(e);
        end
        araddr  = 8'h10;
        arvalid = 1'b1;
        check("same_edge_arready", arready, 1);
        tick();
        arvalid = 1'b0;
        check("same_edge_bvalid", bvalid, 1);
        check("same_edge_rvalid", rvalid, 1);
        model_write(8'h08, 32'hCAFEF00D, 5'h03);
        tick();
        do_read(8'h08, 32'h00BBF00D, 1'b0);
        do_read(8'h10, 32'd4, 1'b0);

        // All-zero strobe still counts as a successful write
        do_write(8'h00, 32'hFFFFFFFF, 5'h00, 1'b0, 0);
        do_read(8'h00, 32'h0, 1'b0);
        do_read(8'h10, 32'd5, 1'b0);

        // 6: interleaved writes to regs 0/1 and reads of regs 2/3
        do_write(8'h00, 32'h17, 5'h0F, 1'b0, 0);
        d = 32'h17;
        for (int i = 0; i < 4; i++) begin
            d = d + 32'd7;
            do_write((i % 2 != 0) ? 8'h04 : 8'h00, d, 5'h0F, 1'b0, 0);
            do_read((i % 2 != 0) ? 8'h0C : 8'h08, m_regs[(i % 2 != 0) ? 3 : 2], 1'b0);
            check_regs("t6");
        end
        check("t6_reg0", m_regs[0], 32'h2C);
        check("t6_reg1", m_regs[1], 32'h33);
        do_read(8'h10, 32'd10, 1'b0);

        // Reset between handshake and commit: nothing commits
        awaddr  = 8'h04;
        wdata   = 32'h00000055;
        wstrb   = 5'h0F;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        aresetn = 1'b0;
        #2;
        model_reset();
        check("midrst_bvalid", bvalid, 0);
        check_regs("midrst");
        tick();
        tick();
        check("midrst_bvalid_hold", bvalid, 0);
        aresetn = 1'b1;
        tick();
        check("postrst_awready", awready, 1);
        check("postrst_wready", wready, 1);
        do_read(8'h04, 32'h0, 1'b0);
        do_read(8'h10, 32'h0, 1'b0);

        n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 10) begin
            tick();
            n++;
        end
        check("scoreboard_drain", exp_b.size() + exp_r.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
